// File: rtl/pixel_block_fetch_pkg.sv
// Shared types and frame geometry for the 8x8 block fetch/write pipeline.
package pixel_block_fetch_pkg;

    typedef enum logic [2:0] {
        PF_IDLE,
        PF_LEAD_IN,
        PF_COMMON,
        PF_LEAD_OUT,
        PF_DONE
    } PF_state_type;

    typedef enum logic [1:0] {
        SEG_Y,
        SEG_U,
        SEG_V
    } segment_type;

    localparam logic [17:0] Y_BASE_DEFAULT = 18'd0;
    localparam logic [17:0] U_BASE_DEFAULT = 18'd38400;
    localparam logic [17:0] V_BASE_DEFAULT = 18'd57600;
    localparam int unsigned Y_WPR_DEFAULT  = 160;
    localparam int unsigned UV_WPR_DEFAULT = 80;
    localparam int unsigned ROWS_DEFAULT   = 240;

    function automatic segment_type next_segment(input segment_type seg);
        case (seg)
            SEG_Y:   return SEG_U;
            SEG_U:   return SEG_V;
            default: return SEG_Y;
        endcase
    endfunction

endpackage

// File: rtl/pixel_block_fetch_addr_gen.sv
// Block position counters, SRAM read address generation and the
// two-stage delayed RAM write addressing that matches SRAM read latency.
module pixel_block_addr_gen
    import pixel_block_fetch_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEFAULT,
    parameter logic [17:0] U_BASE = U_BASE_DEFAULT,
    parameter logic [17:0] V_BASE = V_BASE_DEFAULT,
    parameter int unsigned Y_WPR  = Y_WPR_DEFAULT,
    parameter int unsigned UV_WPR = UV_WPR_DEFAULT,
    parameter int unsigned ROWS   = ROWS_DEFAULT
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        fetch_start,
    input  logic        block_advance,
    output logic [17:0] SRAM_address,
    output logic        read_last,
    output logic        capture_pending,
    output logic        last_block,
    output logic        ram_write,
    output logic [6:0]  ram_addr_even,
    output logic [6:0]  ram_addr_odd
);

    localparam logic [4:0] RB_LAST    = 5'(ROWS / 8 - 1);
    localparam logic [5:0] Y_CB_LAST  = 6'(Y_WPR / 4 - 1);
    localparam logic [5:0] UV_CB_LAST = 6'(UV_WPR / 4 - 1);

    segment_type segment;
    logic [4:0]  rb;
    logic [5:0]  cb;
    logic [4:0]  k;
    logic        rd_valid;
    logic        v_d1, v_d2;
    logic [4:0]  k_d1, k_d2;
    logic [5:0]  cb_last;
    logic [17:0] base;
    logic [17:0] wpr;
    logic [17:0] row;

    always_comb begin
        base    = Y_BASE;
        wpr     = 18'(Y_WPR);
        cb_last = Y_CB_LAST;
        case (segment)
            SEG_U: begin
                base    = U_BASE;
                wpr     = 18'(UV_WPR);
                cb_last = UV_CB_LAST;
            end
            SEG_V: begin
                base    = V_BASE;
                wpr     = 18'(UV_WPR);
                cb_last = UV_CB_LAST;
            end
            default: ;
        endcase
        row = 18'({rb, 3'b000}) + 18'(k[4:2]);
        SRAM_address = rd_valid
            ? (base + row * wpr + 18'({cb, 2'b00}) + 18'(k[1:0]))
            : '0;
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            segment  <= SEG_Y;
            rb       <= '0;
            cb       <= '0;
            k        <= '0;
            rd_valid <= 1'b0;
            v_d1     <= 1'b0;
            v_d2     <= 1'b0;
            k_d1     <= '0;
            k_d2     <= '0;
        end else begin
            if (fetch_start) begin
                rd_valid <= 1'b1;
                k        <= '0;
            end else if (rd_valid) begin
                if (k == 5'd31)
                    rd_valid <= 1'b0;
                k <= k + 5'd1;
            end
            // word index rides along with the SRAM latency so the write lands with its data
            v_d1 <= rd_valid;
            k_d1 <= k;
            v_d2 <= v_d1;
            k_d2 <= k_d1;

            if (block_advance) begin
                if (cb == cb_last) begin
                    cb <= '0;
                    if (rb == RB_LAST) begin
                        rb      <= '0;
                        segment <= next_segment(segment);
                    end else begin
                        rb <= rb + 5'd1;
                    end
                end else begin
                    cb <= cb + 6'd1;
                end
            end
        end
    end

    assign read_last       = rd_valid && (k == 5'd31);
    assign capture_pending = v_d1;
    assign last_block      = (segment == SEG_V) && (rb == RB_LAST) && (cb == UV_CB_LAST);
    assign ram_write       = v_d2;
    assign ram_addr_even   = v_d2 ? {1'b0, k_d2, 1'b0} : '0;
    assign ram_addr_odd    = v_d2 ? {1'b0, k_d2, 1'b1} : '0;

endmodule

// File: rtl/pixel_block_fetch.sv
// Fetches one 8x8 block of packed 8-bit pixels from SRAM per start pulse and
// unpacks it into 64 zero-extended samples on both RAM write ports.
module pixel_block_fetch
    import pixel_block_fetch_pkg::*;
#(
    parameter logic [17:0] Y_BASE = Y_BASE_DEFAULT,
    parameter logic [17:0] U_BASE = U_BASE_DEFAULT,
    parameter logic [17:0] V_BASE = V_BASE_DEFAULT,
    parameter int unsigned Y_WPR  = Y_WPR_DEFAULT,
    parameter int unsigned UV_WPR = UV_WPR_DEFAULT,
    parameter int unsigned ROWS   = ROWS_DEFAULT
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    input  logic        PF_start,
    output logic        PF_done,
    output logic        PF_memory_end,
    output logic [6:0]  RAM_address_a,
    output logic [31:0] RAM_write_data_a,
    output logic        RAM_write_enable_a,
    output logic [6:0]  RAM_address_b,
    output logic [31:0] RAM_write_data_b,
    output logic        RAM_write_enable_b
);

    PF_state_type state, state_n;
    logic fetch_start;
    logic read_last;
    logic capture_pending;
    logic last_block;
    logic ram_write;
    logic mem_end_hold;

    pixel_block_addr_gen #(
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE),
        .Y_WPR  (Y_WPR),
        .UV_WPR (UV_WPR),
        .ROWS   (ROWS)
    ) u_addr_gen (
        .CLOCK_50_I      (CLOCK_50_I),
        .Resetn          (Resetn),
        .fetch_start     (fetch_start),
        .block_advance   (PF_done),
        .SRAM_address    (SRAM_address),
        .read_last       (read_last),
        .capture_pending (capture_pending),
        .last_block      (last_block),
        .ram_write       (ram_write),
        .ram_addr_even   (RAM_address_a),
        .ram_addr_odd    (RAM_address_b)
    );

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state        <= PF_IDLE;
            mem_end_hold <= 1'b0;
        end else begin
            state <= state_n;
            if (fetch_start)
                mem_end_hold <= 1'b0;
            else if (state == PF_DONE && last_block)
                mem_end_hold <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_start = 1'b0;
        PF_done     = 1'b0;
        case (state)
            PF_IDLE: begin
                fetch_start = PF_start;
                if (PF_start)
                    state_n = PF_LEAD_IN;
            end
            PF_LEAD_IN:  if (capture_pending) state_n = PF_COMMON;
            PF_COMMON:   if (read_last) state_n = PF_LEAD_OUT;
            PF_LEAD_OUT: if (!capture_pending) state_n = PF_DONE;
            PF_DONE: begin
                PF_done = 1'b1;
                state_n = PF_IDLE;
            end
            default: state_n = PF_IDLE;
        endcase
    end

    // counters still point at the finishing block during DONE, so flag it in the same cycle
    assign PF_memory_end      = mem_end_hold | (PF_done & last_block);
    assign SRAM_we_n          = 1'b1;
    assign RAM_write_enable_a = ram_write;
    assign RAM_write_enable_b = ram_write;
    assign RAM_write_data_a   = ram_write ? {24'd0, SRAM_read_data[15:8]} : '0;
    assign RAM_write_data_b   = ram_write ? {24'd0, SRAM_read_data[7:0]} : '0;

endmodule

// File: tb/tb_pixel_block_fetch.sv
// Self-checking bench: full-geometry instance with a write scoreboard, plus a
// reduced-geometry instance to reach plane transitions and frame end quickly.
module tb_pixel_block_fetch;

    logic CLOCK_50_I = 1'b0;
    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic        Resetn;

    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = '0;
    logic        SRAM_we_n;
    logic        PF_start;
    logic        PF_done;
    logic        PF_memory_end;
    logic [6:0]  RAM_address_a, RAM_address_b;
    logic [31:0] RAM_write_data_a, RAM_write_data_b;
    logic        RAM_write_enable_a, RAM_write_enable_b;

    logic [17:0] s_SRAM_address;
    logic [15:0] s_SRAM_read_data = '0;
    logic        s_SRAM_we_n;
    logic        s_PF_start;
    logic        s_PF_done;
    logic        s_PF_memory_end;
    logic [6:0]  s_RAM_address_a, s_RAM_address_b;
    logic [31:0] s_RAM_write_data_a, s_RAM_write_data_b;
    logic        s_RAM_write_enable_a, s_RAM_write_enable_b;

    pixel_block_fetch dut (
        .CLOCK_50_I         (CLOCK_50_I),
        .Resetn             (Resetn),
        .SRAM_address       (SRAM_address),
        .SRAM_read_data     (SRAM_read_data),
        .SRAM_we_n          (SRAM_we_n),
        .PF_start           (PF_start),
        .PF_done            (PF_done),
        .PF_memory_end      (PF_memory_end),
        .RAM_address_a      (RAM_address_a),
        .RAM_write_data_a   (RAM_write_data_a),
        .RAM_write_enable_a (RAM_write_enable_a),
        .RAM_address_b      (RAM_address_b),
        .RAM_write_data_b   (RAM_write_data_b),
        .RAM_write_enable_b (RAM_write_enable_b)
    );

    pixel_block_fetch #(
        .Y_BASE (18'd0),
        .U_BASE (18'd1000),
        .V_BASE (18'd2000),
        .Y_WPR  (8),
        .UV_WPR (4),
        .ROWS   (16)
    ) dut_s (
        .CLOCK_50_I         (CLOCK_50_I),
        .Resetn             (Resetn),
        .SRAM_address       (s_SRAM_address),
        .SRAM_read_data     (s_SRAM_read_data),
        .SRAM_we_n          (s_SRAM_we_n),
        .PF_start           (s_PF_start),
        .PF_done            (s_PF_done),
        .PF_memory_end      (s_PF_memory_end),
        .RAM_address_a      (s_RAM_address_a),
        .RAM_write_data_a   (s_RAM_write_data_a),
        .RAM_write_enable_a (s_RAM_write_enable_a),
        .RAM_address_b      (s_RAM_address_b),
        .RAM_write_data_b   (s_RAM_write_data_b),
        .RAM_write_enable_b (s_RAM_write_enable_b)
    );

    function automatic logic [15:0] sram_word(input logic [17:0] a);
        logic [15:0] h;
        if (a == 18'd0)
            return 16'h1234;
        h = 16'(a[15:0] * 16'd40503);
        return h ^ {a[17:16], 14'h2a5};
    endfunction

    // two-cycle read latency SRAM models
    logic [15:0] rd_pipe = '0, s_rd_pipe = '0;
    always @(posedge CLOCK_50_I) begin
        rd_pipe          <= sram_word(SRAM_address);
        SRAM_read_data   <= rd_pipe;
        s_rd_pipe        <= sram_word(s_SRAM_address);
        s_SRAM_read_data <= s_rd_pipe;
    end

    typedef struct packed {
        logic [6:0]  addr_a;
        logic [31:0] data_a;
        logic [6:0]  addr_b;
        logic [31:0] data_b;
    } wr_t;

    typedef struct {
        int unsigned blk;
        logic [17:0] first;
        logic [17:0] last;
    } mvec_t;

    typedef struct {
        logic [17:0] first;
        logic [17:0] last;
        logic        mend;
    } svec_t;

    wr_t         sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned blk_count = 0;
    int unsigned dups = 0;
    logic [63:0] seen;
    logic [17:0] exp_addr [32];
    mvec_t       main_vec [3];
    svec_t       small_vec [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50_I) begin
        if (Resetn === 1'b1 && (RAM_write_enable_a === 1'b1 || RAM_write_enable_b === 1'b1)) begin
            wr_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr_a=%0d with empty scoreboard", RAM_address_a);
            end else begin
                e = sb.pop_front();
                check("wr_en_b", {63'd0, RAM_write_enable_b}, 64'd1);
                check("wr_addr_a", {57'd0, RAM_address_a}, {57'd0, e.addr_a});
                check("wr_data_a", {32'd0, RAM_write_data_a}, {32'd0, e.data_a});
                check("wr_addr_b", {57'd0, RAM_address_b}, {57'd0, e.addr_b});
                check("wr_data_b", {32'd0, RAM_write_data_b}, {32'd0, e.data_b});
            end
            if (seen[RAM_address_a[5:0]]) dups++;
            seen[RAM_address_a[5:0]] = 1'b1;
            if (seen[RAM_address_b[5:0]]) dups++;
            seen[RAM_address_b[5:0]] = 1'b1;
        end
    end

    function automatic logic [17:0] model_addr(input int unsigned bi, input int unsigned k);
        int unsigned base, wpr, rb, cb, j;
        if (bi < 1200) begin
            base = 0; wpr = 160; rb = bi / 40; cb = bi % 40;
        end else if (bi < 1800) begin
            j = bi - 1200; base = 38400; wpr = 80; rb = j / 20; cb = j % 20;
        end else begin
            j = bi - 1800; base = 57600; wpr = 80; rb = j / 20; cb = j % 20;
        end
        return 18'(base + (rb * 8 + k / 4) * wpr + cb * 4 + k % 4);
    endfunction

    task automatic prep_block(input int unsigned bi);
        logic [15:0] w;
        for (int unsigned k = 0; k < 32; k++) begin
            exp_addr[k] = model_addr(bi, k);
            w = sram_word(exp_addr[k]);
            sb.push_back('{addr_a: 7'((k / 4) * 8 + (k % 4) * 2),
                           data_a: {24'd0, w[15:8]},
                           addr_b: 7'((k / 4) * 8 + (k % 4) * 2 + 1),
                           data_b: {24'd0, w[7:0]}});
        end
    endtask

    task automatic run_block(input bit inject);
        logic [17:0] first_a;
        logic [17:0] last_a;
        first_a = '0;
        last_a  = '0;
        prep_block(blk_count);
        @(negedge CLOCK_50_I);
        seen = '0;
        dups = 0;
        PF_start = 1'b1;
        @(posedge CLOCK_50_I);
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLOCK_50_I);
            PF_start = inject && (c == 5 || c == 35);
            if (c <= 32)
                check("sram_addr", {46'd0, SRAM_address}, {46'd0, exp_addr[c-1]});
            if (c == 1) first_a = SRAM_address;
            if (c == 32) last_a = SRAM_address;
            check("done_timing", {63'd0, PF_done}, {63'd0, (c == 35)});
            check("wr_window", {62'd0, RAM_write_enable_a, RAM_write_enable_b},
                  (c >= 3 && c <= 34) ? 64'd3 : 64'd0);
            if (blk_count == 0 && c == 3) begin
                check("t1_addr_a", {57'd0, RAM_address_a}, 64'd0);
                check("t1_data_a", {32'd0, RAM_write_data_a}, 64'h12);
                check("t1_addr_b", {57'd0, RAM_address_b}, 64'd1);
                check("t1_data_b", {32'd0, RAM_write_data_b}, 64'h34);
            end
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (blk_count == 0) begin
            check("ram_cover", seen, '1);
            check("ram_dups", 64'(dups), 64'd0);
        end
        foreach (main_vec[i]) begin
            if (main_vec[i].blk == blk_count) begin
                check("vec_first", {46'd0, first_a}, {46'd0, main_vec[i].first});
                check("vec_last", {46'd0, last_a}, {46'd0, main_vec[i].last});
            end
        end
        blk_count++;
    endtask

    task automatic run_small(input int idx);
        @(negedge CLOCK_50_I);
        s_PF_start = 1'b1;
        @(posedge CLOCK_50_I);
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLOCK_50_I);
            s_PF_start = 1'b0;
            if (c == 1) begin
                check("s_first", {46'd0, s_SRAM_address}, {46'd0, small_vec[idx].first});
                check("s_mend_clear", {63'd0, s_PF_memory_end}, 64'd0);
            end
            if (c == 32)
                check("s_last", {46'd0, s_SRAM_address}, {46'd0, small_vec[idx].last});
            check("s_done", {63'd0, s_PF_done}, {63'd0, (c == 35)});
            if (c == 35 || c == 40)
                check("s_mend", {63'd0, s_PF_memory_end}, {63'd0, small_vec[idx].mend});
        end
    endtask

    initial begin
        main_vec[0] = '{blk: 0,  first: 18'd0,    last: 18'd1123};
        main_vec[1] = '{blk: 39, first: 18'd156,  last: 18'd1279};
        main_vec[2] = '{blk: 40, first: 18'd1280, last: 18'd2403};

        small_vec[0] = '{first: 18'd0,    last: 18'd59,   mend: 1'b0};
        small_vec[1] = '{first: 18'd4,    last: 18'd63,   mend: 1'b0};
        small_vec[2] = '{first: 18'd64,   last: 18'd123,  mend: 1'b0};
        small_vec[3] = '{first: 18'd68,   last: 18'd127,  mend: 1'b0};
        small_vec[4] = '{first: 18'd1000, last: 18'd1031, mend: 1'b0};
        small_vec[5] = '{first: 18'd1032, last: 18'd1063, mend: 1'b0};
        small_vec[6] = '{first: 18'd2000, last: 18'd2031, mend: 1'b0};
        small_vec[7] = '{first: 18'd2032, last: 18'd2063, mend: 1'b1};
        small_vec[8] = '{first: 18'd0,    last: 18'd59,   mend: 1'b0};

        Resetn     = 1'b0;
        PF_start   = 1'b0;
        s_PF_start = 1'b0;
        seen       = '0;
        repeat (3) @(negedge CLOCK_50_I);
        check("rst_sram_addr", {46'd0, SRAM_address}, 64'd0);
        check("rst_we_n", {63'd0, SRAM_we_n}, 64'd1);
        check("rst_done", {63'd0, PF_done}, 64'd0);
        check("rst_mend", {63'd0, PF_memory_end}, 64'd0);
        check("rst_ram_a", {31'd0, RAM_address_a, RAM_write_data_a, RAM_write_enable_a}, 64'd0);
        check("rst_ram_b", {31'd0, RAM_address_b, RAM_write_data_b, RAM_write_enable_b}, 64'd0);
        Resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50_I);

        for (int b = 0; b < 41; b++)
            run_block(1'b0);
        run_block(1'b1);

        for (int i = 0; i < 9; i++)
            run_small(i);

        // abort a block mid-flight with reset, then restart the frame
        prep_block(blk_count);
        @(negedge CLOCK_50_I);
        PF_start = 1'b1;
        @(posedge CLOCK_50_I);
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLOCK_50_I);
            PF_start = 1'b0;
        end
        #2 Resetn = 1'b0;
        #1;
        check("abort_en", {62'd0, RAM_write_enable_a, RAM_write_enable_b}, 64'd0);
        check("abort_done", {63'd0, PF_done}, 64'd0);
        check("abort_addr", {46'd0, SRAM_address}, 64'd0);
        sb.delete();
        blk_count = 0;
        repeat (2) @(negedge CLOCK_50_I);
        check("abort_en_hold", {62'd0, RAM_write_enable_a, RAM_write_enable_b}, 64'd0);
        Resetn = 1'b1;
        run_block(1'b0);
        run_block(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
